// File: rtl/relogio_pkg.sv
// Shared definitions for the clock digit blocks: active-high 7-segment glyphs
// (bit order {a,b,c,d,e,f,g}) and the digit operating modes.
package relogio_pkg;

  typedef enum logic [1:0] {
    ModeRun,
    ModeHold,
    ModeSet
  } mode_e;

  localparam logic [6:0] Glyph0 = 7'h7E;
  localparam logic [6:0] Glyph1 = 7'h30;
  localparam logic [6:0] Glyph2 = 7'h6D;
  localparam logic [6:0] Glyph3 = 7'h79;
  localparam logic [6:0] Glyph4 = 7'h33;
  localparam logic [6:0] Glyph5 = 7'h5B;
  localparam logic [6:0] Glyph6 = 7'h5F;
  localparam logic [6:0] Glyph7 = 7'h70;
  localparam logic [6:0] Glyph8 = 7'h7F;
  localparam logic [6:0] Glyph9 = 7'h7B;
  localparam logic [6:0] GlyphA = 7'h77;
  localparam logic [6:0] GlyphB = 7'h1F;
  localparam logic [6:0] GlyphC = 7'h4E;
  localparam logic [6:0] GlyphD = 7'h3D;
  localparam logic [6:0] GlyphE = 7'h4F;
  localparam logic [6:0] GlyphF = 7'h47;

  function automatic logic [6:0] glyph(input logic [3:0] digit);
    logic [6:0] lit;
    unique case (digit)
      4'h0: lit = Glyph0;
      4'h1: lit = Glyph1;
      4'h2: lit = Glyph2;
      4'h3: lit = Glyph3;
      4'h4: lit = Glyph4;
      4'h5: lit = Glyph5;
      4'h6: lit = Glyph6;
      4'h7: lit = Glyph7;
      4'h8: lit = Glyph8;
      4'h9: lit = Glyph9;
      4'hA: lit = GlyphA;
      4'hB: lit = GlyphB;
      4'hC: lit = GlyphC;
      4'hD: lit = GlyphD;
      4'hE: lit = GlyphE;
      4'hF: lit = GlyphF;
    endcase
    return lit;
  endfunction

endpackage

// File: rtl/decod_7seg.sv
// Combinational hex to 7-segment decoder with blanking and selectable polarity.
module decod_7seg
  import relogio_pkg::*;
#(
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic [3:0] digit_i,
  input  logic       blank_i,
  output logic [6:0] seg_o
);

  logic [6:0] lit;

  always_comb begin
    lit = glyph(digit_i);
    if (blank_i) begin
      lit = '0;
    end
    seg_o = SEG_ACTIVE_LOW ? ~lit : lit;
  end

endmodule

// File: rtl/contador_digito_mod.sv
// Single-digit modulo counter with carry/borrow chaining, load, clear, debounced
// manual adjust and registered 7-segment drive.
module contador_digito_mod
  import relogio_pkg::*;
#(
  parameter int unsigned MODULO         = 10,
  parameter int unsigned RESET_VALUE    = 0,
  parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       tick,
  input  logic       up_down,
  input  logic       clear,
  input  logic       load,
  input  logic [3:0] load_value,
  input  logic       set_mode,
  input  logic       adjust_n,
  input  logic       blank,
  output logic [3:0] value,
  output logic       carry_out,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       d,
  output logic       e,
  output logic       f,
  output logic       g
);

  localparam logic [3:0] MaxVal   = 4'(MODULO - 1);
  localparam logic [3:0] ResetVal = 4'(RESET_VALUE);
  localparam logic [4:0] ModVal   = 5'(MODULO);

  mode_e      mode;
  logic [3:0] value_q, value_d;
  logic       carry_q, carry_d;
  logic [6:0] seg_q, seg_d;
  logic       sync1_q, sync2_q, prev_q;
  logic       adjust_fall;

  // Button is active-low: a press is a 1 -> 0 transition of the synchronised level.
  assign adjust_fall = prev_q & ~sync2_q;

  always_comb begin
    mode = ModeRun;
    if (clear) begin
      mode = ModeHold;
    end else if (set_mode) begin
      mode = ModeSet;
    end
  end

  always_comb begin
    value_d = value_q;
    carry_d = 1'b0;
    if (reset) begin
      value_d = ResetVal;
    end else if (mode == ModeHold) begin
      value_d = '0;
    end else if (load) begin
      if ({1'b0, load_value} < ModVal) begin
        value_d = load_value;
      end
    end else if (mode == ModeSet) begin
      // Manual adjust wraps silently so setting the time never ripples a carry.
      if (adjust_fall) begin
        value_d = (value_q == MaxVal) ? 4'd0 : value_q + 4'd1;
      end
    end else if (tick) begin
      if (up_down) begin
        if (value_q == MaxVal) begin
          value_d = '0;
          carry_d = 1'b1;
        end else begin
          value_d = value_q + 4'd1;
        end
      end else begin
        if (value_q == 4'd0) begin
          value_d = MaxVal;
          carry_d = 1'b1;
        end else begin
          value_d = value_q - 4'd1;
        end
      end
    end
  end

  // Decode the next value so the glyph register updates on the same edge as value.
  decod_7seg #(
    .SEG_ACTIVE_LOW (SEG_ACTIVE_LOW)
  ) u_decod (
    .digit_i (value_d),
    .blank_i (blank),
    .seg_o   (seg_d)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      value_q <= ResetVal;
      carry_q <= 1'b0;
      seg_q   <= seg_d;
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      value_q <= value_d;
      carry_q <= carry_d;
      seg_q   <= seg_d;
      sync1_q <= adjust_n;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign value     = value_q;
  assign carry_out = carry_q;
  assign {a, b, c, d, e, f, g} = seg_q;

endmodule

// File: tb/tb_contador_digito_mod.sv
// Scoreboard bench: three digits (MODULO 10, 6, 3) driven with directed vectors.
module tb_contador_digito_mod;

  logic clock = 1'b0;
  logic reset;
  logic [2:0] tick, up_down, clear, load, set_mode, adjust_n, blank;
  logic [3:0] lv [3];
  logic [2:0][3:0] val;
  logic [2:0] cy;
  logic [2:0][6:0] seg;

  typedef struct {
    int         id;
    logic [3:0] v;
    logic       c;
    logic [6:0] s;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clock = ~clock;

  contador_digito_mod #(.MODULO(10)) u_m10 (
    .clock(clock), .reset(reset), .tick(tick[0]), .up_down(up_down[0]), .clear(clear[0]),
    .load(load[0]), .load_value(lv[0]), .set_mode(set_mode[0]), .adjust_n(adjust_n[0]),
    .blank(blank[0]), .value(val[0]), .carry_out(cy[0]),
    .a(seg[0][6]), .b(seg[0][5]), .c(seg[0][4]), .d(seg[0][3]), .e(seg[0][2]),
    .f(seg[0][1]), .g(seg[0][0])
  );

  contador_digito_mod #(.MODULO(6)) u_m6 (
    .clock(clock), .reset(reset), .tick(tick[1]), .up_down(up_down[1]), .clear(clear[1]),
    .load(load[1]), .load_value(lv[1]), .set_mode(set_mode[1]), .adjust_n(adjust_n[1]),
    .blank(blank[1]), .value(val[1]), .carry_out(cy[1]),
    .a(seg[1][6]), .b(seg[1][5]), .c(seg[1][4]), .d(seg[1][3]), .e(seg[1][2]),
    .f(seg[1][1]), .g(seg[1][0])
  );

  contador_digito_mod #(.MODULO(3)) u_m3 (
    .clock(clock), .reset(reset), .tick(tick[2]), .up_down(up_down[2]), .clear(clear[2]),
    .load(load[2]), .load_value(lv[2]), .set_mode(set_mode[2]), .adjust_n(adjust_n[2]),
    .blank(blank[2]), .value(val[2]), .carry_out(cy[2]),
    .a(seg[2][6]), .b(seg[2][5]), .c(seg[2][4]), .d(seg[2][3]), .e(seg[2][2]),
    .f(seg[2][1]), .g(seg[2][0])
  );

  // Hand-derived active-low glyphs, {a..g}.
  function automatic logic [6:0] lo_glyph(input int v);
    case (v)
      0: return 7'h01;  1: return 7'h4F;  2: return 7'h12;  3: return 7'h06;
      4: return 7'h4C;  5: return 7'h24;  6: return 7'h20;  7: return 7'h0F;
      8: return 7'h00;  9: return 7'h04;  10: return 7'h08; 11: return 7'h60;
      12: return 7'h31; 13: return 7'h42; 14: return 7'h30; default: return 7'h38;
    endcase
  endfunction

  // Called at a negedge after inputs are set; expectation is for after the next posedge.
  task automatic step(input int id, input int v, input bit c);
    exp_t x;
    x.id = id;
    x.v  = 4'(v);
    x.c  = c;
    x.s  = blank[id] ? 7'h7F : lo_glyph(v);
    exp_q.push_back(x);
    @(negedge clock);
  endtask

  task automatic idle();
    tick = '0; up_down = '1; clear = '0; load = '0; set_mode = '0;
    adjust_n = '1; blank = '0;
    for (int i = 0; i < 3; i++) lv[i] = '0;
  endtask

  // Monitor: pops one expectation per clock, sampling 1 time unit after the edge.
  initial begin
    exp_t x;
    forever begin
      @(posedge clock);
      #1;
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        n_checks++;
        if (val[x.id] !== x.v) begin
          n_fail++;
          $display("FAIL value dut%0d t=%0t: got %0d expected %0d", x.id, $time, val[x.id], x.v);
        end
        n_checks++;
        if (cy[x.id] !== x.c) begin
          n_fail++;
          $display("FAIL carry dut%0d t=%0t: got %0b expected %0b", x.id, $time, cy[x.id], x.c);
        end
        n_checks++;
        if (seg[x.id] !== x.s) begin
          n_fail++;
          $display("FAIL seg dut%0d t=%0t: got %h expected %h", x.id, $time, seg[x.id], x.s);
        end
      end
    end
  end

  initial begin
    idle();
    reset = 1'b1;
    @(negedge clock);
    step(0, 0, 0);
    step(1, 0, 0);
    step(2, 0, 0);
    reset = 1'b0;

    // MODULO 10 up: 12 ticks, carry only on 9 -> 0.
    tick[0] = 1'b1;
    for (int i = 1; i <= 12; i++) step(0, i % 10, (i == 10));
    tick[0] = 1'b0;
    step(0, 2, 0);

    // MODULO 6 down from 0: borrow to 5 for exactly one cycle.
    up_down[1] = 1'b0; tick[1] = 1'b1;
    step(1, 5, 1);
    tick[1] = 1'b0;
    step(1, 5, 0);

    // Load: out of range ignored, in range taken, load beats tick.
    load[1] = 1'b1; lv[1] = 4'd7;
    step(1, 5, 0);
    lv[1] = 4'd3;
    step(1, 3, 0);
    lv[1] = 4'd0; tick[1] = 1'b1;
    step(1, 0, 0);
    load[1] = 1'b0; tick[1] = 1'b0;
    step(1, 0, 0);

    // Clear held with ticks: stays 0, no carry, then counts from 0.
    tick[0] = 1'b1;
    step(0, 3, 0);
    step(0, 4, 0);
    clear[0] = 1'b1;
    for (int i = 0; i < 5; i++) step(0, 0, 0);
    clear[0] = 1'b0;
    step(0, 1, 0);
    step(0, 2, 0);
    tick[0] = 1'b0;

    // SET on MODULO 3 from 2: held button gives a single silent wrap to 0.
    tick[2] = 1'b1;
    step(2, 1, 0);
    step(2, 2, 0);
    set_mode[2] = 1'b1; adjust_n[2] = 1'b0;
    for (int i = 1; i <= 20; i++) step(2, (i >= 3) ? 0 : 2, 0);
    adjust_n[2] = 1'b1;
    for (int i = 0; i < 4; i++) step(2, 0, 0);
    set_mode[2] = 1'b0;
    step(2, 1, 0);
    tick[2] = 1'b0;

    // Blank at value 8, then release.
    load[0] = 1'b1; lv[0] = 4'd8;
    step(0, 8, 0);
    load[0] = 1'b0; blank[0] = 1'b1;
    step(0, 8, 0);
    blank[0] = 1'b0;
    step(0, 8, 0);

    // Reset beats a wrapping tick.
    tick[0] = 1'b1;
    step(0, 9, 0);
    reset = 1'b1;
    step(0, 0, 0);
    reset = 1'b0;
    step(0, 1, 0);
    tick[0] = 1'b0;

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clock);
    if (exp_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
